// File: rtl/uart_cmd_parser.sv
// ASCII command-line parser: "w addr data\r" / "r addr\r" into a
// valid/ready command bundle, with error pulses and codes.
module uart_cmd_parser #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              iCLK,
  input  logic              iRESETn,
  input  logic              iRX_VALID,
  input  logic [7:0]        iRX_DATA,
  output logic              oCMD_VALID,
  input  logic              iCMD_READY,
  output logic              oCMD_WRITE,
  output logic [ADDR_W-1:0] oCMD_ADDR,
  output logic [DATA_W-1:0] oCMD_WDATA,
  output logic              oERR,
  output logic [1:0]        oERR_CODE,
  output logic              oBUSY
);

  localparam int AD = ADDR_W / 4;
  localparam int DD = DATA_W / 4;
  localparam int MD = (AD > DD) ? AD : DD;
  localparam int CW = $clog2(MD + 1);

  localparam logic [7:0] SP = 8'h20;
  localparam logic [7:0] CR = 8'h0D;

  typedef enum logic [2:0] {
    IDLE, SP0, ADDR, DATA, ISSUE, ERROR
  } state_t;

  state_t            state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;

  logic       is_hex;
  logic [3:0] nib;
  logic [7:0] b;

  assign b = iRX_DATA;

  always_comb begin
    is_hex = 1'b1;
    nib    = b[3:0];
    unique case (1'b1)
      (b >= 8'h30 && b <= 8'h39): nib = b[3:0];
      (b >= 8'h61 && b <= 8'h66): nib = b[3:0] + 4'd9;
      (b >= 8'h41 && b <= 8'h46): nib = b[3:0] + 4'd9;
      default:                    is_hex = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    code_d  = code_q;
    unique case (state_q)
      IDLE: if (iRX_VALID) begin
        if (b == 8'h77 || b == 8'h57) begin
          wr_d    = 1'b1;
          state_d = SP0;
        end else if (b == 8'h72 || b == 8'h52) begin
          wr_d    = 1'b0;
          state_d = SP0;
        end else if (b != CR) begin
          state_d = ERROR;
          err_d   = 1'b1;
          code_d  = 2'd1;
        end
      end
      SP0: if (iRX_VALID) begin
        if (b == SP) begin
          addr_d  = '0;
          data_d  = '0;
          cnt_d   = '0;
          state_d = ADDR;
        end else begin
          state_d = ERROR;
          err_d   = 1'b1;
          code_d  = 2'd2;
        end
      end
      ADDR: if (iRX_VALID) begin
        if (is_hex && cnt_q == CW'(AD)) begin
          state_d = ERROR;
          err_d   = 1'b1;
          code_d  = 2'd3;
        end else if (is_hex) begin
          addr_d = {addr_q[ADDR_W-5:0], nib};
          cnt_d  = cnt_q + CW'(1);
        end else if (b == SP && wr_q && cnt_q != '0) begin
          cnt_d   = '0;
          state_d = DATA;
        end else if (b == CR && !wr_q && cnt_q != '0) begin
          state_d = ISSUE;
        end else begin
          state_d = ERROR;
          err_d   = 1'b1;
          code_d  = 2'd2;
        end
      end
      DATA: if (iRX_VALID) begin
        if (is_hex && cnt_q == CW'(DD)) begin
          state_d = ERROR;
          err_d   = 1'b1;
          code_d  = 2'd3;
        end else if (is_hex) begin
          data_d = {data_q[DATA_W-5:0], nib};
          cnt_d  = cnt_q + CW'(1);
        end else if (b == CR && cnt_q != '0) begin
          state_d = ISSUE;
        end else begin
          state_d = ERROR;
          err_d   = 1'b1;
          code_d  = 2'd2;
        end
      end
      ISSUE: begin
        // overrun: byte dropped, payload untouched
        if (iRX_VALID) begin
          err_d  = 1'b1;
          code_d = 2'd0;
        end
        if (iCMD_READY) state_d = IDLE;
      end
      ERROR: if (iRX_VALID && b == CR) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRESETn) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign oCMD_VALID = (state_q == ISSUE);
  assign oCMD_WRITE = wr_q;
  assign oCMD_ADDR  = addr_q;
  assign oCMD_WDATA = data_q;
  assign oERR       = err_q;
  assign oERR_CODE  = code_q;
  assign oBUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: default 32/32 and a 16/8 instance.
module tb_uart_cmd_parser;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        rv, rdy, vld, wr, err, busy;
  logic [7:0]  rd;
  logic [31:0] addr, wdata;
  logic [1:0]  code;

  logic        s_rv, s_rdy, s_vld, s_wr, s_err, s_busy;
  logic [7:0]  s_rd;
  logic [15:0] s_addr;
  logic [7:0]  s_wdata;
  logic [1:0]  s_code;

  int vecs = 0;
  int errs = 0;

  uart_cmd_parser dut (
    .iCLK(clk), .iRESETn(rst_n),
    .iRX_VALID(rv), .iRX_DATA(rd),
    .oCMD_VALID(vld), .iCMD_READY(rdy),
    .oCMD_WRITE(wr), .oCMD_ADDR(addr),
    .oCMD_WDATA(wdata), .oERR(err),
    .oERR_CODE(code), .oBUSY(busy)
  );

  uart_cmd_parser #(.ADDR_W(16), .DATA_W(8)) dut_s (
    .iCLK(clk), .iRESETn(rst_n),
    .iRX_VALID(s_rv), .iRX_DATA(s_rd),
    .oCMD_VALID(s_vld), .iCMD_READY(s_rdy),
    .oCMD_WRITE(s_wr), .oCMD_ADDR(s_addr),
    .oCMD_WDATA(s_wdata), .oERR(s_err),
    .oERR_CODE(s_code), .oBUSY(s_busy)
  );

  task automatic send(input bit sel, input logic [7:0] b);
    @(negedge clk);
    if (sel) begin s_rv = 1'b1; s_rd = b; end
    else begin rv = 1'b1; rd = b; end
    @(negedge clk);
    rv   = 1'b0;
    s_rv = 1'b0;
  endtask

  task automatic send_str(input bit sel, input string s);
    for (int i = 0; i < s.len(); i++) send(sel, s[i]);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rv = 1'b0; rd = 8'h00; rdy = 1'b0;
    s_rv = 1'b0; s_rd = 8'h00; s_rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    vecs++;
    if ({vld, wr, err, code, busy, addr, wdata} !== 70'd0) begin
      errs++;
      $display("FAIL reset_outs got %h want 0",
               {vld, wr, err, code, busy, addr, wdata});
    end
    vecs++;
    if ({s_vld, s_err, s_busy, s_addr, s_wdata} !== 27'd0) begin
      errs++;
      $display("FAIL reset_small got %h want 0",
               {s_vld, s_err, s_busy, s_addr, s_wdata});
    end
  endtask

  task automatic test_write;
    rdy = 1'b1;
    send_str(0, "w 1000 DEADbeef");
    vecs++;
    if (vld !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL wr_pre_cr got vld=%b busy=%b want 0 1", vld, busy);
    end
    send(0, 8'h0D);
    vecs++;
    if ({vld, wr, addr, wdata} !== {2'b11, 32'h00001000, 32'hDEADBEEF}) begin
      errs++;
      $display("FAIL wr_issue got %b %b %h %h want 1 1 00001000 deadbeef",
               vld, wr, addr, wdata);
    end
    @(negedge clk);
    vecs++;
    if (vld !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL wr_done got vld=%b busy=%b want 0 0", vld, busy);
    end
  endtask

  task automatic test_read_stall;
    rdy = 1'b0;
    send_str(0, "r A");
    send(0, 8'h0D);
    for (int i = 0; i < 6; i++) begin
      vecs++;
      if ({vld, wr, addr, wdata} !== {2'b10, 32'h0000000A, 32'h0}) begin
        errs++;
        $display("FAIL rd_hold%0d got %b %b %h %h want 1 0 0000000a 0",
                 i, vld, wr, addr, wdata);
      end
      if (i == 5) rdy = 1'b1;
      if (i == 1) begin rv = 1'b1; rd = 8'h78; end
      @(negedge clk);
      rv = 1'b0;
      if (i == 1) begin
        vecs++;
        if (err !== 1'b1 || code !== 2'd0) begin
          errs++;
          $display("FAIL overrun got err=%b code=%0d want 1 0", err, code);
        end
      end
    end
    vecs++;
    if (vld !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL rd_done got vld=%b busy=%b want 0 0", vld, busy);
    end
  endtask

  task automatic test_bad_cmd;
    rdy = 1'b1;
    send(0, 8'h71);
    vecs++;
    if (err !== 1'b1 || code !== 2'd1 || busy !== 1'b1) begin
      errs++;
      $display("FAIL bad_cmd got err=%b code=%0d busy=%b want 1 1 1",
               err, code, busy);
    end
    send_str(0, " 1");
    vecs++;
    if (err !== 1'b0 || vld !== 1'b0) begin
      errs++;
      $display("FAIL err_discard got err=%b vld=%b want 0 0", err, vld);
    end
    send(0, 8'h0D);
    vecs++;
    if ({busy, vld, err, code} !== 5'b00001) begin
      errs++;
      $display("FAIL err_exit got %b want 00001", {busy, vld, err, code});
    end
    send_str(0, "R 2");
    send(0, 8'h0D);
    vecs++;
    if ({vld, wr, addr} !== {2'b10, 32'h2}) begin
      errs++;
      $display("FAIL rd_after_err got %b %b %h want 1 0 2", vld, wr, addr);
    end
    @(negedge clk);
  endtask

  task automatic test_format_errs;
    send_str(0, "w 12345678");
    send(0, 8'h39);
    vecs++;
    if (err !== 1'b1 || code !== 2'd3) begin
      errs++;
      $display("FAIL addr_ovf got err=%b code=%0d want 1 3", err, code);
    end
    send_str(0, " 1");
    send(0, 8'h0D);
    vecs++;
    if (busy !== 1'b0 || vld !== 1'b0) begin
      errs++;
      $display("FAIL ovf_exit got busy=%b vld=%b want 0 0", busy, vld);
    end
    send_str(0, "w 12");
    send(0, 8'h0D);
    vecs++;
    if (err !== 1'b1 || code !== 2'd2 || vld !== 1'b0) begin
      errs++;
      $display("FAIL wr_no_data got err=%b code=%0d vld=%b want 1 2 0",
               err, code, vld);
    end
    send(0, 8'h0D);
    send(0, 8'h0D);
    vecs++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      errs++;
      $display("FAIL blank_line got busy=%b err=%b want 0 0", busy, err);
    end
    send_str(0, "r ");
    send(0, 8'h0D);
    vecs++;
    if (err !== 1'b1 || code !== 2'd2) begin
      errs++;
      $display("FAIL rd_no_addr got err=%b code=%0d want 1 2", err, code);
    end
    send(0, 8'h0D);
  endtask

  task automatic test_reset_mid;
    send_str(0, "w 10 5");
    vecs++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL mid_busy got %b want 1", busy);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 8'h0D);
    vecs++;
    if ({vld, wr, err, code, busy, addr, wdata} !== 70'd0) begin
      errs++;
      $display("FAIL reset_mid got %h want 0",
               {vld, wr, err, code, busy, addr, wdata});
    end
  endtask

  task automatic test_back_to_back;
    rdy = 1'b1;
    send_str(0, "r 5");
    send(0, 8'h0D);
    vecs++;
    if ({vld, wr, addr, wdata} !== {2'b10, 32'h5, 32'h0}) begin
      errs++;
      $display("FAIL b2b_rd got %b %b %h %h want 1 0 5 0",
               vld, wr, addr, wdata);
    end
    send_str(0, "W aB 7");
    send(0, 8'h0D);
    vecs++;
    if ({vld, wr, addr, wdata} !== {2'b11, 32'hAB, 32'h7}) begin
      errs++;
      $display("FAIL b2b_wr got %b %b %h %h want 1 1 ab 7",
               vld, wr, addr, wdata);
    end
    @(negedge clk);
  endtask

  task automatic test_small;
    s_rdy = 1'b1;
    send_str(1, "w FFFF FF");
    send(1, 8'h0D);
    vecs++;
    if ({s_vld, s_wr, s_addr, s_wdata} !== {2'b11, 16'hFFFF, 8'hFF}) begin
      errs++;
      $display("FAIL small_max got %b %b %h %h want 1 1 ffff ff",
               s_vld, s_wr, s_addr, s_wdata);
    end
    @(negedge clk);
    send_str(1, "w 1 12");
    vecs++;
    if (s_err !== 1'b0) begin
      errs++;
      $display("FAIL small_2dig got err=%b want 0", s_err);
    end
    send(1, 8'h33);
    vecs++;
    if (s_err !== 1'b1 || s_code !== 2'd3) begin
      errs++;
      $display("FAIL small_ovf got err=%b code=%0d want 1 3", s_err, s_code);
    end
    send(1, 8'h0D);
    vecs++;
    if (s_busy !== 1'b0 || s_vld !== 1'b0) begin
      errs++;
      $display("FAIL small_exit got busy=%b vld=%b want 0 0", s_busy, s_vld);
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read_stall;
    test_bad_cmd;
    test_format_errs;
    test_reset_mid;
    test_back_to_back;
    test_small;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width in bits, a multiple of 4.
REQ-002 SHALL have parameter DATA_W, default 32: data width in bits, a multiple of 4.
REQ-003 SHALL have port iCLK, input, 1 bit: the single clock; all logic rises on its posedge.
REQ-004 SHALL have port iRESETn, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port iRX_VALID, input, 1 bit: one-cycle strobe marking a received byte.
REQ-006 SHALL have port iRX_DATA, input, 8 bits: received ASCII byte, valid when iRX_VALID=1.
REQ-007 SHALL have port oCMD_VALID, output, 1 bit: a parsed command is presented.
REQ-008 SHALL have port iCMD_READY, input, 1 bit: the consumer accepts the command.
REQ-009 SHALL have port oCMD_WRITE, output, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port oCMD_ADDR, output, ADDR_W bits: parsed address.
REQ-011 SHALL have port oCMD_WDATA, output, DATA_W bits: parsed write data; 0 for reads.
REQ-012 SHALL have port oERR, output, 1 bit: one-cycle error pulse.
REQ-013 SHALL have port oERR_CODE, output, 2 bits: cause of the error; held until the next error.
REQ-014 SHALL have port oBUSY, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL parse the grammar "w<SP>addr<SP>data<CR>" or "r<SP>addr<CR>":
- Command character: w/W = write, r/R = read.
- SP = 0x20; CR = 0x0D.
- addr and data are hex digits 0-9, a-f, A-F.
REQ-016 SHALL implement the states IDLE, SP0, ADDR, DATA, ISSUE and ERROR.
REQ-017 In IDLE: w/W/r/R SHALL latch the command type and go to SP0; any other byte SHALL go to ERROR with code 1.
REQ-018 In SP0: SP SHALL clear the address and data accumulators and the digit counter, then go to ADDR; any other byte SHALL go to ERROR with code 2.
REQ-019 In ADDR, each hex digit SHALL be shifted into the address accumulator, acc = {acc[ADDR_W-5:0], nibble}, and increment the digit counter.
REQ-020 In ADDR, the terminating byte SHALL be handled as follows, all cases requiring at least 1 digit:
- SP on a write SHALL go to DATA and reset the counter.
- CR on a read SHALL go to ISSUE.
- Every other case SHALL go to ERROR with code 2.
REQ-021 In DATA, hex digits SHALL accumulate in the same way; CR with at least 1 digit SHALL go to ISSUE; anything else SHALL go to ERROR with code 2.
REQ-022 A digit arriving when the counter already holds ADDR_W/4 (or DATA_W/4) digits SHALL go to ERROR with code 3.
REQ-023 Fewer digits than the maximum SHALL be zero-extended, because the accumulator starts at 0.
REQ-024 The CR accepted in cycle N SHALL assert oCMD_VALID in cycle N+1.
REQ-025 In ISSUE: oCMD_VALID, oCMD_WRITE, oCMD_ADDR and oCMD_WDATA SHALL be held stable until a cycle in which iCMD_READY=1.
REQ-026 That transfer cycle SHALL return the block to IDLE, with oCMD_VALID=0 on the next cycle.
REQ-027 iCMD_READY SHALL be ignored when oCMD_VALID=0.
REQ-028 Bytes arriving in ISSUE SHALL be dropped and pulse oERR with code 0 (overrun); the state and payload SHALL not change.
REQ-029 Entry into ERROR SHALL pulse oERR for exactly one cycle and update oERR_CODE.
REQ-030 ERROR SHALL discard bytes until a CR, which SHALL return the block to IDLE without further pulses.
REQ-031 A CR received in IDLE SHALL be ignored silently, so blank lines are not errors.
REQ-032 Bytes SHALL be consumed only in cycles with iRX_VALID=1; in all other cycles the state SHALL hold.

Reset
REQ-033 iRESETn=0 sampled at a posedge SHALL force IDLE in any state, including mid-command and ISSUE.
REQ-034 On that reset the outputs SHALL take these values:
- oCMD_VALID=0, oCMD_WRITE=0, oERR=0, oERR_CODE=0, oBUSY=0.
- oCMD_ADDR=0, oCMD_WDATA=0.
- The digit counter SHALL be cleared.
REQ-035 A partially parsed command SHALL be lost on reset, and no error pulse SHALL be issued.

Verification
REQ-036 A bench SHALL cover the following directed scenarios (default ADDR_W=DATA_W=32):
- "w 1000 DEADbeef\r", iCMD_READY=1 -> one-cycle oCMD_VALID with WRITE=1, ADDR=0x00001000, WDATA=0xDEADBEEF, in the cycle after the CR.
- "r A\r", iCMD_READY=0 for 5 cycles then 1 -> VALID held 6 cycles with ADDR=0x0000000A, WRITE=0, WDATA=0; extra byte 'x' sent meanwhile -> oERR pulse with code 0 and payload unchanged.
- "q 1\r" -> oERR with code 1 on 'q'; no VALID; oBUSY low after the CR; then "r 2\r" -> VALID with ADDR=2.
- "w 123456789 1\r" -> oERR with code 3 on the 9th digit; "w 12\r" -> code 2 on the CR; "r \r" -> code 2.
- "w 10 5" then iRESETn=0 for 1 cycle, then "\r" -> no VALID, no oERR, all outputs 0.
- ADDR_W=16, DATA_W=8: "w FFFF FF\r" -> ADDR=0xFFFF, WDATA=0xFF; "w 1 123\r" -> oERR with code 3.
